// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan driver.
// Segment patterns are active-low, bit 0 = segment a .. bit 6 = segment g.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t HEX_SEG [16] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000,   // 9
        7'b0001000,   // A
        7'b0000011,   // b
        7'b1000110,   // C
        7'b0100001,   // d
        7'b0000110,   // E
        7'b0001110    // F
    };

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed, double-buffered driver for common-anode hex seven-segment digits.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LZ_SUPPRESS_EN.
module seven_segment_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int REFRESH_COUNT = 24000,
    parameter int GUARD_CYCLES  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame
);

    localparam int CNT_W = $clog2(REFRESH_COUNT);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_blank;

    logic                    slot_end;
    logic                    last_idx;
    logic                    frame_end;
    logic                    in_guard;
    logic                    dark;
    logic [3:0]              nibble;
    seg_t                    dec_seg;
    seg_t                    seg_next;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [NUM_DIGITS-1:0]   lz_mask;

    assign slot_end  = (cnt == CNT_W'(REFRESH_COUNT - 1));
    assign last_idx  = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_end = slot_end && last_idx;
    assign in_guard  = (cnt < CNT_W'(GUARD_CYCLES));

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    // Darken zeros from the top digit down until the first nonzero; digit 0 always shows.
    always_comb begin
        logic leading;
        lz_mask = '0;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (act_digits[4*i +: 4] != 4'h0) begin
                leading = 1'b0;
            end
            lz_mask[i] = leading;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign nibble = act_digits[4*int'(idx) +: 4];
    assign dark   = act_blank[idx] | lz_mask[idx];

    seven_segment_decoder u_decoder (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_next   = SEG_BLANK;
        anode_next = '1;
        if (!in_guard) begin
            anode_next = ~(NUM_DIGITS'(1) << idx);
            seg_next   = dark ? SEG_BLANK : dec_seg;
        end
    end

    // A load landing on the frame boundary bypasses pending so it shows in the very next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            pend_digits <= '0;
            pend_blank  <= '1;
            act_digits  <= '0;
            act_blank   <= '1;
            seg         <= SEG_BLANK;
            anode       <= '1;
            frame       <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                idx <= last_idx ? '0 : idx + IDX_W'(1);
            end
            if (load) begin
                pend_digits <= digits;
                pend_blank  <= blank;
            end
            if (frame_end) begin
                act_digits <= load ? digits : pend_digits;
                act_blank  <= load ? blank  : pend_blank;
            end
            frame <= frame_end;
            seg   <= seg_next;
            anode <= anode_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan: a time-based display model predicts every output cycle.
// Leading-zero expectations follow SEVEN_SEG_LZ_SUPPRESS_EN when it is defined.
module tb_seven_segment_scan;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int G     = 1;
    localparam int FRAME = N * R;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  digits;
    logic [3:0]   blank;
    logic         load;
    logic [6:0]   seg;
    logic [3:0]   anode;
    logic         frame;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] anode;
        logic       frame;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    int          m_t = 0;
    logic [15:0] m_pend_d, m_act_d;
    logic [3:0]  m_pend_b, m_act_b;

    seven_segment_scan #(
        .NUM_DIGITS    (N),
        .REFRESH_COUNT (R),
        .GUARD_CYCLES  (G)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .digits (digits),
        .blank  (blank),
        .load   (load),
        .seg    (seg),
        .anode  (anode),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] table_g2a [16];
        table_g2a = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return table_g2a[n];
    endfunction

    // Highest nonzero digit position decides how far down zeros are hidden.
    function automatic bit lz_dark(input logic [15:0] d, input int slot);
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        int top;
        top = 0;
        for (int i = 0; i < N; i++) begin
            if (((d >> (4 * i)) & 16'hF) != 16'h0) top = i;
        end
        return slot > top;
`else
        return (d == 16'hFFFF) && (slot > N);
`endif
    endfunction

    task automatic model_edge();
        exp_t e;
        int   cnt;
        int   slot;
        bit   bnd;
        logic [3:0] nib;
        if (reset) begin
            e        = '{seg: 7'h7F, anode: 4'hF, frame: 1'b0};
            m_t      = 0;
            m_pend_d = '0;
            m_act_d  = '0;
            m_pend_b = 4'hF;
            m_act_b  = 4'hF;
        end else begin
            cnt  = m_t % R;
            slot = (m_t / R) % N;
            bnd  = (m_t % FRAME) == FRAME - 1;
            nib  = 4'((m_act_d >> (4 * slot)) & 16'hF);
            if (cnt < G) begin
                e.seg   = 7'h7F;
                e.anode = 4'hF;
            end else begin
                e.anode = 4'hF & ~(4'b0001 << slot);
                e.seg   = (m_act_b[slot] || lz_dark(m_act_d, slot)) ? 7'h7F : ref_seg(nib);
            end
            e.frame = bnd;
            if (load) begin
                m_pend_d = digits;
                m_pend_b = blank;
            end
            if (bnd) begin
                m_act_d = m_pend_d;
                m_act_b = m_pend_b;
            end
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    // Inputs set here are sampled on the next edge; m_t then holds the DUT's current cnt/idx position.
    task automatic apply_stimulus(input bit rst, input bit ld, input logic [15:0] d, input logic [3:0] b);
        reset  = rst;
        load   = ld;
        digits = d;
        blank  = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_until(input int phase);
        for (int i = 0; i < 4 * FRAME && (m_t % FRAME) != phase; i++) idle(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg) begin
                errors++;
                $display("[TB] FAIL seg t=%0t got %b want %b", $time, seg, e.seg);
            end
            checks++;
            if (anode !== e.anode) begin
                errors++;
                $display("[TB] FAIL anode t=%0t got %b want %b", $time, anode, e.anode);
            end
            checks++;
            if (frame !== e.frame) begin
                errors++;
                $display("[TB] FAIL frame t=%0t got %b want %b", $time, frame, e.frame);
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic [3:0]  b;
        bit          rst;
        bit          ld;

        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        idle(20);

        apply_stimulus(1'b0, 1'b1, 16'h0000, 4'h0);
        idle(2 * FRAME);

        apply_stimulus(1'b0, 1'b1, 16'h4321, 4'h0);
        idle(3 * FRAME);

        run_until(6);
        apply_stimulus(1'b0, 1'b1, 16'hABCD, 4'h0);
        idle(2 * FRAME);

        run_until(FRAME - 1);
        apply_stimulus(1'b0, 1'b1, 16'h5A5A, 4'h0);
        idle(FRAME + 3);

        apply_stimulus(1'b0, 1'b1, 16'h1234, 4'b0101);
        idle(2 * FRAME);

        apply_stimulus(1'b0, 1'b1, 16'h0050, 4'h0);
        idle(2 * FRAME);
        apply_stimulus(1'b0, 1'b1, 16'h0000, 4'h0);
        idle(2 * FRAME);

        run_until(2);
        apply_stimulus(1'b0, 1'b1, 16'h9876, 4'h0);
        run_until(11);
        apply_stimulus(1'b1, 1'b0, 16'h0, 4'h0);
        idle(2 * FRAME);

        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 999) < 3);
            if ((m_t % FRAME) == FRAME - 1) ld = ($urandom_range(0, 2) == 0);
            else                            ld = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < N; i++) begin
                d[4*i +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            apply_stimulus(rst, ld, d, b);
        end

        idle(2);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
